// File: rtl/esm_pkg.sv
// Shared types and helpers for the issue scheduler: entry states, one-hot
// register masks and the head-relative age compare.
package esm_pkg;
  localparam int IRT_BS     = 32;
  localparam int IRT_REGNUM = 16;

  typedef enum logic [1:0] {FREE, WAIT, ISSUED, DONE} entry_state_t;

  // x0 (and anything out of range) never contributes to a hazard mask
  function automatic logic [IRT_REGNUM-1:0] reg_onehot(input int unsigned idx,
                                                       input int unsigned regnum);
    reg_onehot = '0;
    if (idx != 0 && idx < regnum) reg_onehot = IRT_REGNUM'(1) << idx;
  endfunction

  // j older than i when its distance from head is smaller; bs is a power of two
  function automatic logic is_older(input int unsigned j, input int unsigned i,
                                    input int unsigned head, input int unsigned bs);
    return ((j - head) & (bs - 1)) < ((i - head) & (bs - 1));
  endfunction
endpackage

// File: rtl/irt_issue_scheduler_if.sv
// Alloc / issue / complete / retire bundle of the issue scheduler.
// Stats outputs exist only when IRT_SCHED_STATS_EN is defined.
interface irt_issue_scheduler_if #(
  parameter int BS     = esm_pkg::IRT_BS,
  parameter int REGNUM = esm_pkg::IRT_REGNUM
);
  localparam int IW = $clog2(BS);
  localparam int RW = $clog2(REGNUM);

  logic          alloc_valid, alloc_ready;
  logic [RW-1:0] alloc_rd, alloc_rs1, alloc_rs2;
  logic [IW-1:0] alloc_idx;
  logic          issue_valid, issue_ready;
  logic [IW-1:0] issue_idx;
  logic [RW-1:0] issue_rd;
  logic          complete_valid;
  logic [IW-1:0] complete_idx;
  logic          retire_valid;
  logic [IW-1:0] retire_idx;
  logic          empty;
`ifdef IRT_SCHED_STATS_EN
  logic [31:0]   stat_issue_cnt, stat_stall_cnt;
`endif

  modport slave (
    input  alloc_valid, alloc_rd, alloc_rs1, alloc_rs2, issue_ready,
           complete_valid, complete_idx,
    output alloc_ready, alloc_idx, issue_valid, issue_idx, issue_rd,
           retire_valid, retire_idx, empty
`ifdef IRT_SCHED_STATS_EN
    , output stat_issue_cnt, stat_stall_cnt
`endif
  );

  modport master (
    output alloc_valid, alloc_rd, alloc_rs1, alloc_rs2, issue_ready,
           complete_valid, complete_idx,
    input  alloc_ready, alloc_idx, issue_valid, issue_idx, issue_rd,
           retire_valid, retire_idx, empty
`ifdef IRT_SCHED_STATS_EN
    , input stat_issue_cnt, stat_stall_cnt
`endif
  );
endinterface

// File: rtl/irt_hazard_matrix.sv
// Combinational readiness: an entry is ready when WAIT and no older in-flight
// entry has a RAW/WAW/WAR overlap with it.
module irt_hazard_matrix import esm_pkg::*; #(
  parameter int BS     = IRT_BS,
  parameter int REGNUM = IRT_REGNUM
) (
  input  entry_state_t                 state_i [BS],
  input  logic [BS-1:0][REGNUM-1:0]    rd_mask_i,
  input  logic [BS-1:0][REGNUM-1:0]    rs_mask_i,
  input  logic [$clog2(BS)-1:0]        head_i,
  output logic [BS-1:0]                ready_o
);
  logic blk;

  always_comb begin
    ready_o = '0;
    blk     = 1'b0;
    for (int i = 0; i < BS; i++) begin
      blk = 1'b0;
      for (int j = 0; j < BS; j++) begin
        // DONE/FREE entries have released their registers
        if (j != i && (state_i[j] == WAIT || state_i[j] == ISSUED) &&
            is_older(j, i, 32'(head_i), BS) &&
            |((rd_mask_i[j] & (rs_mask_i[i] | rd_mask_i[i])) |
              (rs_mask_i[j] & rd_mask_i[i])))
          blk = 1'b1;
      end
      ready_o[i] = (state_i[i] == WAIT) && !blk;
    end
  end
endmodule

// File: rtl/irt_issue_scheduler.sv
// In-order allocate/retire, out-of-order issue scheduler. Optional counters
// enabled by IRT_SCHED_STATS_EN.
module irt_issue_scheduler import esm_pkg::*; #(
  parameter int BS     = IRT_BS,
  parameter int REGNUM = IRT_REGNUM
) (
  input logic                  clk,
  input logic                  rst,
  irt_issue_scheduler_if.slave bus
);
  localparam int IW = $clog2(BS);
  localparam int RW = $clog2(REGNUM);

  entry_state_t              state_q [BS];
  logic [BS-1:0][REGNUM-1:0] rd_mask_q, rs_mask_q;
  logic [BS-1:0][RW-1:0]     rd_idx_q;
  logic [IW-1:0]             head_q, tail_q;
  logic [IW:0]               cnt_q, cnt_d;
  logic [BS-1:0]             ready;
  logic [IW-1:0]             sel, cand;
  logic                      sel_vld, alloc_fire, issue_fire, retire_fire, cmpl_hit;

  irt_hazard_matrix #(.BS(BS), .REGNUM(REGNUM)) u_haz (
    .state_i   (state_q),
    .rd_mask_i (rd_mask_q),
    .rs_mask_i (rs_mask_q),
    .head_i    (head_q),
    .ready_o   (ready)
  );

  // walk youngest to oldest so the oldest ready entry wins
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = BS - 1; k >= 0; k--) begin
      cand = head_q + IW'(k);
      if (ready[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  assign bus.alloc_ready  = (cnt_q != (IW+1)'(BS));
  assign bus.alloc_idx    = tail_q;
  assign bus.issue_valid  = sel_vld;
  assign bus.issue_idx    = sel;
  assign bus.issue_rd     = rd_idx_q[sel];
  assign bus.retire_valid = retire_fire;
  assign bus.retire_idx   = head_q;
  assign bus.empty        = (cnt_q == '0);

  assign alloc_fire  = bus.alloc_valid && bus.alloc_ready;
  assign issue_fire  = sel_vld && bus.issue_ready;
  assign retire_fire = (cnt_q != '0) && (state_q[head_q] == DONE);
  assign cmpl_hit    = bus.complete_valid && (state_q[bus.complete_idx] == ISSUED);
  assign cnt_d       = cnt_q + (IW+1)'(alloc_fire) - (IW+1)'(retire_fire);

  // alloc/issue/complete/retire always hit distinct entries, so the
  // per-index writes below never collide
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int e = 0; e < BS; e++) state_q[e] <= FREE;
      rd_mask_q <= '0;
      rs_mask_q <= '0;
      rd_idx_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (alloc_fire) begin
        state_q[tail_q]   <= WAIT;
        rd_mask_q[tail_q] <= REGNUM'(reg_onehot(32'(bus.alloc_rd), REGNUM));
        rs_mask_q[tail_q] <= REGNUM'(reg_onehot(32'(bus.alloc_rs1), REGNUM) |
                                     reg_onehot(32'(bus.alloc_rs2), REGNUM));
        rd_idx_q[tail_q]  <= bus.alloc_rd;
        tail_q            <= tail_q + IW'(1);
      end
      if (issue_fire) state_q[sel] <= ISSUED;
      if (cmpl_hit)   state_q[bus.complete_idx] <= DONE;
      if (retire_fire) begin
        state_q[head_q]   <= FREE;
        rd_mask_q[head_q] <= '0;
        rs_mask_q[head_q] <= '0;
        rd_idx_q[head_q]  <= '0;
        head_q            <= head_q + IW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

`ifdef IRT_SCHED_STATS_EN
  logic [31:0] stat_issue_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (issue_fire) stat_issue_q <= stat_issue_q + 32'd1;
      if (cnt_q != '0 && !sel_vld) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign bus.stat_issue_cnt = stat_issue_q;
  assign bus.stat_stall_cnt = stat_stall_q;
`endif
endmodule

// File: tb/tb_irt_issue_scheduler.sv
// Directed bench for irt_issue_scheduler: reset, RAW/WAR blocking, independent
// issue, x0 handling, full/wrap boundaries and mid-run reset.
module tb_irt_issue_scheduler;
  localparam int BS     = 32;
  localparam int REGNUM = 16;

  logic clk, rst;
  int   total, passed;

  irt_issue_scheduler_if #(.BS(BS), .REGNUM(REGNUM)) bus ();

  irt_issue_scheduler #(.BS(BS), .REGNUM(REGNUM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic alloc(input logic v, input int rd, input int rs1, input int rs2);
    bus.alloc_valid = v;
    bus.alloc_rd    = 4'(rd);
    bus.alloc_rs1   = 4'(rs1);
    bus.alloc_rs2   = 4'(rs2);
  endtask

  task automatic cmpl(input logic v, input int idx);
    bus.complete_valid = v;
    bus.complete_idx   = 5'(idx);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < BS + 4 && !bus.empty; k++) tick();
    chk(tag, 32'(bus.empty), 1);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b0;
    alloc(0, 0, 0, 0);
    cmpl(0, 0);
    bus.issue_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("rst_empty",   32'(bus.empty), 1);
    chk("rst_aready",  32'(bus.alloc_ready), 1);
    chk("rst_ivalid",  32'(bus.issue_valid), 0);
    chk("rst_rvalid",  32'(bus.retire_valid), 0);
    chk("rst_aidx",    32'(bus.alloc_idx), 0);
    chk("rst_iidx",    32'(bus.issue_idx), 0);
    chk("rst_ridx",    32'(bus.retire_idx), 0);

    // RAW: add x3,x1,x2 ; add x4,x3,x5
    bus.issue_ready = 1'b1;
    alloc(1, 3, 1, 2);
    chk("raw_aidx0", 32'(bus.alloc_idx), 0);
    chk("raw_not_yet", 32'(bus.issue_valid), 0);
    tick();
    alloc(1, 4, 3, 5);
    chk("raw_aidx1", 32'(bus.alloc_idx), 1);
    chk("raw_iv0",   32'(bus.issue_valid), 1);
    chk("raw_ii0",   32'(bus.issue_idx), 0);
    chk("raw_ird0",  32'(bus.issue_rd), 3);
    tick();
    alloc(0, 0, 0, 0);
    chk("raw_blk_issued", 32'(bus.issue_valid), 0);
    tick();
    cmpl(1, 0);
    chk("raw_blk_cmpl", 32'(bus.issue_valid), 0);
    tick();
    cmpl(0, 0);
    chk("raw_iv1",  32'(bus.issue_valid), 1);
    chk("raw_ii1",  32'(bus.issue_idx), 1);
    chk("raw_ird1", 32'(bus.issue_rd), 4);
    chk("raw_rv0",  32'(bus.retire_valid), 1);
    chk("raw_ri0",  32'(bus.retire_idx), 0);
    tick();
    cmpl(1, 1);
    chk("raw_idle", 32'(bus.issue_valid), 0);
    chk("raw_empty_no", 32'(bus.empty), 0);
    tick();
    cmpl(0, 0);
    chk("raw_rv1", 32'(bus.retire_valid), 1);
    chk("raw_ri1", 32'(bus.retire_idx), 1);
    tick();
    chk("raw_empty", 32'(bus.empty), 1);

    // independent instructions issue back to back
    alloc(1, 3, 1, 0);
    chk("ind_aidx2", 32'(bus.alloc_idx), 2);
    tick();
    alloc(1, 5, 6, 0);
    chk("ind_ii2", 32'(bus.issue_idx), 2);
    tick();
    alloc(1, 7, 8, 0);
    chk("ind_ii3", 32'(bus.issue_idx), 3);
    tick();
    alloc(0, 0, 0, 0);
    chk("ind_iv4", 32'(bus.issue_valid), 1);
    chk("ind_ii4", 32'(bus.issue_idx), 4);
    tick();
    bus.issue_ready = 1'b0;
    cmpl(1, 2); tick();
    cmpl(1, 3); tick();
    cmpl(1, 4); tick();
    cmpl(0, 0);
    drain("ind_drain");

    // WAR: entry5 reads x4, entry6 writes x4
    alloc(1, 2, 4, 0);
    chk("war_aidx5", 32'(bus.alloc_idx), 5);
    tick();
    alloc(1, 4, 1, 0);
    chk("war_ii5", 32'(bus.issue_idx), 5);
    tick();
    alloc(0, 0, 0, 0);
    chk("war_hold_iv", 32'(bus.issue_valid), 1);
    chk("war_hold_ii", 32'(bus.issue_idx), 5);
    bus.issue_ready = 1'b1;
    tick();
    chk("war_blk", 32'(bus.issue_valid), 0);
    cmpl(1, 5);
    tick();
    cmpl(0, 0);
    chk("war_iv6", 32'(bus.issue_valid), 1);
    chk("war_ii6", 32'(bus.issue_idx), 6);
    tick();
    bus.issue_ready = 1'b0;
    cmpl(1, 6);
    tick();
    cmpl(0, 0);
    drain("war_drain");

    // x0 never hazards; complete to a WAIT entry is ignored
    alloc(1, 0, 1, 2); tick();
    alloc(1, 0, 3, 4); tick();
    alloc(1, 5, 0, 0); tick();
    alloc(0, 0, 0, 0);
    cmpl(1, 8);
    tick();
    cmpl(0, 0);
    chk("x0_iv",  32'(bus.issue_valid), 1);
    chk("x0_ii7", 32'(bus.issue_idx), 7);
    chk("x0_rv",  32'(bus.retire_valid), 0);
    bus.issue_ready = 1'b1;
    tick();
    chk("x0_ii8", 32'(bus.issue_idx), 8);
    tick();
    chk("x0_ii9", 32'(bus.issue_idx), 9);
    tick();
    chk("x0_idle", 32'(bus.issue_valid), 0);
    bus.issue_ready = 1'b0;
    cmpl(1, 7); tick();
    cmpl(1, 8); tick();
    cmpl(1, 9); tick();
    cmpl(0, 0);
    drain("x0_drain");

    // fill from head=10: tail wraps through 0
    for (int k = 0; k < BS; k++) begin
      alloc(1, 0, 0, 0);
      chk("fill_aidx", 32'(bus.alloc_idx), 32'((10 + k) % BS));
      tick();
    end
    chk("full_aready", 32'(bus.alloc_ready), 0);
    chk("full_aidx",   32'(bus.alloc_idx), 10);
    tick();
    chk("full_hold",   32'(bus.alloc_ready), 0);
    chk("full_iihead", 32'(bus.issue_idx), 10);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    cmpl(1, 10);
    tick();
    cmpl(0, 0);
    chk("full_rv",   32'(bus.retire_valid), 1);
    chk("full_ri",   32'(bus.retire_idx), 10);
    chk("full_same", 32'(bus.alloc_ready), 0);
    tick();
    chk("full_freed",  32'(bus.alloc_ready), 1);
    chk("full_reuse",  32'(bus.alloc_idx), 10);
    tick();
    chk("full_again",  32'(bus.alloc_ready), 0);
    alloc(0, 0, 0, 0);

    // reset with a full buffer, complete ignored in reset cycle
    rst = 1'b0;
    cmpl(1, 12);
    tick();
    rst = 1'b1;
    cmpl(0, 0);
    chk("mrst_empty",  32'(bus.empty), 1);
    chk("mrst_aready", 32'(bus.alloc_ready), 1);
    chk("mrst_aidx",   32'(bus.alloc_idx), 0);
    chk("mrst_iv",     32'(bus.issue_valid), 0);
    chk("mrst_rv",     32'(bus.retire_valid), 0);

    // reset with 5 entries in flight
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      alloc(1, 1, 0, 0);
      tick();
    end
    alloc(0, 0, 0, 0);
    chk("r5_busy", 32'(bus.empty), 0);
    rst = 1'b0;
    cmpl(1, 0);
    tick();
    rst = 1'b1;
    cmpl(0, 0);
    chk("r5_empty", 32'(bus.empty), 1);
    chk("r5_iv",    32'(bus.issue_valid), 0);
    chk("r5_ridx",  32'(bus.retire_idx), 0);
    alloc(1, 2, 1, 0);
    tick();
    alloc(0, 0, 0, 0);
    chk("r5_new_iv", 32'(bus.issue_valid), 1);
    chk("r5_new_ii", 32'(bus.issue_idx), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
